// File: rtl/floatdiv.sv
`default_nettype none
// ============================================================================
// floatdiv : iterative fp16 divider, 13-step restoring mantissa division,
//            round-to-nearest (ties away), flush-to-zero, 14-cycle latency.
// Revision : 1.0
// ============================================================================
module floatdiv (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [15:0] a,
  input  logic [15:0] b,
  output logic        busy,
  output logic        done,
  output logic [15:0] o,
  output logic        dbz,
  output logic        ovf,
  output logic        unf
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_DIV  = 2'd1,
    S_NORM = 2'd2
  } state_t;

  localparam logic [3:0] c_last_step = 4'd12;

  state_t       r_state;
  state_t       w_state_nxt;
  logic [3:0]   r_cnt;
  logic [10:0]  r_mb;
  logic [11:0]  r_rem;
  logic [12:0]  r_q;
  logic [4:0]   r_ea;
  logic [4:0]   r_eb;
  logic         r_sign;
  logic         r_za;
  logic         r_zb;
  logic [15:0]  r_o;
  logic         r_dbz;
  logic         r_ovf;
  logic         r_unf;
  logic         r_done;

  logic         w_ge;
  logic [11:0]  w_rem_sub;
  logic [9:0]   w_mant_raw;
  logic         w_rbit;
  logic [10:0]  w_mant_sum;
  logic [6:0]   w_e_u;
  logic signed [6:0] w_e;
  logic [15:0]  w_o;
  logic         w_dbz;
  logic         w_ovf;
  logic         w_unf;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (start) w_state_nxt = S_DIV;
      S_DIV:   if (r_cnt == c_last_step) w_state_nxt = S_NORM;
      S_NORM:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Remainder stays below 2*mb, so 12 bits hold it and the difference fits 11.
  assign w_ge      = (r_rem >= {1'b0, r_mb});
  assign w_rem_sub = w_ge ? (r_rem - {1'b0, r_mb}) : r_rem;

  assign w_mant_raw = r_q[12] ? r_q[11:2] : r_q[10:1];
  assign w_rbit     = r_q[12] ? r_q[1]    : r_q[0];
  assign w_mant_sum = {1'b0, w_mant_raw} + {10'd0, w_rbit};
  assign w_e_u      = {2'b00, r_ea} - {2'b00, r_eb}
                    + (r_q[12] ? 7'd15 : 7'd14)
                    + {6'd0, w_mant_sum[10]};
  assign w_e        = w_e_u;

  always_comb begin
    w_o   = {r_sign, w_e[4:0], w_mant_sum[9:0]};
    w_dbz = 1'b0;
    w_ovf = 1'b0;
    w_unf = 1'b0;
    if (r_za && r_zb) begin
      w_o   = {r_sign, 15'h7E00};
      w_dbz = 1'b1;
    end else if (r_zb) begin
      w_o   = {r_sign, 15'h7C00};
      w_dbz = 1'b1;
    end else if (r_za) begin
      w_o   = {r_sign, 15'h0000};
    end else if (w_e >= 7'sd31) begin
      w_o   = {r_sign, 15'h7C00};
      w_ovf = 1'b1;
    end else if (w_e <= 7'sd0) begin
      w_o   = {r_sign, 15'h0000};
      w_unf = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt  <= 4'd0;
      r_mb   <= 11'd0;
      r_rem  <= 12'd0;
      r_q    <= 13'd0;
      r_ea   <= 5'd0;
      r_eb   <= 5'd0;
      r_sign <= 1'b0;
      r_za   <= 1'b0;
      r_zb   <= 1'b0;
      r_o    <= 16'd0;
      r_dbz  <= 1'b0;
      r_ovf  <= 1'b0;
      r_unf  <= 1'b0;
      r_done <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_sign <= a[15] ^ b[15];
            r_ea   <= a[14:10];
            r_eb   <= b[14:10];
            r_za   <= (a[14:10] == 5'd0);
            r_zb   <= (b[14:10] == 5'd0);
            r_mb   <= {1'b1, b[9:0]};
            r_rem  <= {2'b01, a[9:0]};
            r_q    <= 13'd0;
            r_cnt  <= 4'd0;
          end
        end
        S_DIV: begin
          r_q   <= {r_q[11:0], w_ge};
          r_rem <= {w_rem_sub[10:0], 1'b0};
          r_cnt <= r_cnt + 4'd1;
        end
        S_NORM: begin
          r_o    <= w_o;
          r_dbz  <= w_dbz;
          r_ovf  <= w_ovf;
          r_unf  <= w_unf;
          r_done <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign busy = (r_state != S_IDLE);
  assign done = r_done;
  assign o    = r_o;
  assign dbz  = r_dbz;
  assign ovf  = r_ovf;
  assign unf  = r_unf;

endmodule
`default_nettype wire

// File: tb/tb_floatdiv.sv
`default_nettype none
// ============================================================================
// tb_floatdiv : directed-vector bench for floatdiv with hand-computed results.
// Revision : 1.0
// ============================================================================
module tb_floatdiv;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [15:0] a;
  logic [15:0] b;
  logic        busy;
  logic        done;
  logic [15:0] o;
  logic        dbz;
  logic        ovf;
  logic        unf;

  int n_tests;
  int n_fail;

  floatdiv dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .a     (a),
    .b     (b),
    .busy  (busy),
    .done  (done),
    .o     (o),
    .dbz   (dbz),
    .ovf   (ovf),
    .unf   (unf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Edges counted from now until done is seen; -1 when the budget expires.
  task automatic wait_done(input int max, output int lat);
    lat = -1;
    for (int i = 1; i <= max; i++) begin
      @(posedge clk);
      #1;
      if (done) begin
        lat = i;
        break;
      end
    end
  endtask

  task automatic run_op(input string tag, input logic [15:0] ia, input logic [15:0] ib,
                        input logic [15:0] eo, input logic [2:0] eflags);
    int lat;
    @(negedge clk);
    a = ia;
    b = ib;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    check({tag, " busy"}, {31'd0, busy}, 32'd1);
    wait_done(30, lat);
    check({tag, " latency"}, lat, 32'd14);
    check({tag, " o"}, {16'd0, o}, {16'd0, eo});
    check({tag, " flags"}, {29'd0, dbz, ovf, unf}, {29'd0, eflags});
  endtask

  initial begin
    int lat;
    n_tests = 0;
    n_fail  = 0;
    rst_n = 1'b0;
    start = 1'b0;
    a = 16'h0;
    b = 16'h0;
    repeat (3) @(posedge clk);
    #1;
    check("reset outs", {11'd0, busy, done, dbz, ovf, unf, o}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Basic quotients, rounding and sign
    run_op("1/2",       16'h3C00, 16'h4000, 16'h3800, 3'b000);
    check("done cycle busy", {31'd0, busy}, 32'd0);
    run_op("3/1",       16'h4200, 16'h3C00, 16'h4200, 3'b000);
    run_op("1/3",       16'h3C00, 16'h4200, 16'h3555, 3'b000);
    run_op("2/3",       16'h4000, 16'h4200, 16'h3955, 3'b000);
    run_op("-2/2",      16'hC000, 16'h4000, 16'hBC00, 3'b000);
    run_op("1.5/2.5",   16'h3E00, 16'h4100, 16'h38CD, 3'b000);

    // Zero operands
    run_op("1/0",       16'h3C00, 16'h0000, 16'h7C00, 3'b100);
    run_op("0/0",       16'h0000, 16'h0000, 16'h7E00, 3'b100);
    run_op("-0/1",      16'h8000, 16'h3C00, 16'h8000, 3'b000);
    run_op("denorm/1",  16'h0001, 16'h3C00, 16'h0000, 3'b000);
    run_op("-1/0",      16'hBC00, 16'h0000, 16'hFC00, 3'b100);

    // Exponent range, then a normal op must clear flags
    run_op("ovf",       16'h7800, 16'h0400, 16'h7C00, 3'b010);
    run_op("unf",       16'h0400, 16'h7800, 16'h0000, 3'b001);
    run_op("clear",     16'h3C00, 16'h4000, 16'h3800, 3'b000);

    // start held high: operands re-sampled only in the done cycle
    @(negedge clk);
    a = 16'h3C00;
    b = 16'h4000;
    start = 1'b1;
    @(posedge clk);
    #1;
    a = 16'h4200;
    b = 16'h3C00;
    wait_done(30, lat);
    check("held lat1", lat, 32'd14);
    check("held o1", {16'd0, o}, 32'h3800);
    wait_done(30, lat);
    check("held lat2", lat, 32'd15);
    check("held o2", {16'd0, o}, 32'h4200);
    start = 1'b0;
    @(posedge clk);
    #1;
    check("held stop", {31'd0, busy}, 32'd0);

    // start pulse mid-op is ignored, o held during busy
    @(negedge clk);
    a = 16'h3C00;
    b = 16'h4200;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    a = 16'h7800;
    b = 16'h0400;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    check("hold o busy", {16'd0, o}, 32'h4200);
    wait_done(30, lat);
    check("midpulse lat", lat, 32'd9);
    check("midpulse o", {16'd0, o}, 32'h3555);
    check("midpulse flags", {29'd0, dbz, ovf, unf}, 32'd0);

    // Reset mid-operation aborts with no done
    @(negedge clk);
    a = 16'h4000;
    b = 16'h4200;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("abort outs", {11'd0, busy, done, dbz, ovf, unf, o}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    wait_done(20, lat);
    check("abort no done", lat, 32'hFFFF_FFFF);
    run_op("after rst", 16'h4000, 16'h4200, 16'h3955, 3'b000);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
